// File: rtl/ub_writeback.sv
// ub_writeback: deskews the two VPU output lanes and issues paired writes
// into unified buffer memory in row-major or transposed (column-major) layout.
// Lane 1 is buffered in a small FIFO until its lane-2 partner arrives one or
// more cycles later. A job is started by wb_start_in and ends with a one-cycle
// wb_done_out pulse after the last row's write is issued.
// Optional feature: define UB_WB_BOUNDS_CHECK_EN to suppress and flag writes
// whose element address is at or beyond UB_DEPTH.
module ub_writeback #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int SKEW_DEPTH = 4,
  parameter int UB_DEPTH   = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_start_in,
  input  logic [ADDR_W-1:0] wb_base_addr_in,
  input  logic [ADDR_W-1:0] wb_row_count_in,
  input  logic              wb_transpose_in,
  input  logic [DATA_W-1:0] wb_data_in_1,
  input  logic [DATA_W-1:0] wb_data_in_2,
  input  logic              wb_valid_in_1,
  input  logic              wb_valid_in_2,
  output logic              ub_wr_en_1_out,
  output logic [ADDR_W-1:0] ub_wr_addr_1_out,
  output logic [DATA_W-1:0] ub_wr_data_1_out,
  output logic              ub_wr_en_2_out,
  output logic [ADDR_W-1:0] ub_wr_addr_2_out,
  output logic [DATA_W-1:0] ub_wr_data_2_out,
  output logic              wb_busy_out,
  output logic              wb_done_out,
  output logic              wb_err_out
);

  localparam int PTR_W = $clog2(SKEW_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] rows_reg;
  logic [ADDR_W-1:0] row_cnt_reg;
  logic              transpose_reg;
  logic              issue_reg;

  // Lane-1 deskew storage
  logic [DATA_W-1:0] fifo_mem [SKEW_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;

  logic              active;
  logic              rows_left;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pair_req;
  logic              push_req;
  logic              underflow;
  logic              overflow;
  logic              pair_ok;
  logic              bypass;
  logic              do_push;
  logic              do_pop;
  logic              last_issue;
  logic [DATA_W-1:0] pair_data_1;
  logic [ADDR_W-1:0] row_off;
  logic [ADDR_W-1:0] addr_1_next;
  logic [ADDR_W-1:0] addr_2_next;
  logic              oob_1;
  logic              oob_2;

  // Deskew handshake: decide push, pop, bypass and error conditions this cycle
  always_comb begin
    active     = (state_reg == ACTIVE);
    rows_left  = (row_cnt_reg != rows_reg);
    fifo_empty = (count_reg == '0);
    fifo_full  = (count_reg == CNT_W'(SKEW_DEPTH));
    // Lane-2 valids after the last row has been paired are ignored
    pair_req   = active && wb_valid_in_2 && rows_left;
    push_req   = active && wb_valid_in_1;
    underflow  = pair_req && fifo_empty && !push_req;
    pair_ok    = pair_req && !underflow;
    // Same-cycle lane-1 data goes straight to the pair only when nothing is queued
    bypass     = pair_ok && fifo_empty;
    do_pop     = pair_ok && !fifo_empty;
    do_push    = push_req && !bypass && (!fifo_full || do_pop);
    overflow   = push_req && fifo_full && !do_pop;
    count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    pair_data_1 = bypass ? wb_data_in_1 : fifo_mem[rd_ptr_reg];
    // The counter already holds the new count on the cycle a write is issued
    last_issue = issue_reg && (row_cnt_reg == rows_reg);
  end

  // Destination addresses for the row currently being paired (modulo 2^ADDR_W)
  always_comb begin
    row_off     = transpose_reg ? row_cnt_reg : {row_cnt_reg[ADDR_W-2:0], 1'b0};
    addr_1_next = base_reg + row_off;
    addr_2_next = transpose_reg ? (base_reg + rows_reg + row_cnt_reg)
                                : (base_reg + row_off + ADDR_W'(1));
  end

`ifdef UB_WB_BOUNDS_CHECK_EN
  // Flag element addresses that fall outside the buffer
  always_comb begin
    oob_1 = ({1'b0, addr_1_next} >= (ADDR_W+1)'(UB_DEPTH));
    oob_2 = ({1'b0, addr_2_next} >= (ADDR_W+1)'(UB_DEPTH));
  end
`else
  logic ub_depth_unused;
  assign ub_depth_unused = (UB_DEPTH > 0);
  assign oob_1 = 1'b0;
  assign oob_2 = 1'b0;
`endif

  // FIFO storage write port; contents need no reset because pointers gate reads
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_reg] <= wb_data_in_1;
  end

  // Job FSM, FIFO pointers, row counter and registered write outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      base_reg         <= '0;
      rows_reg         <= '0;
      row_cnt_reg      <= '0;
      transpose_reg    <= 1'b0;
      issue_reg        <= 1'b0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      ub_wr_en_1_out   <= 1'b0;
      ub_wr_addr_1_out <= '0;
      ub_wr_data_1_out <= '0;
      ub_wr_en_2_out   <= 1'b0;
      ub_wr_addr_2_out <= '0;
      ub_wr_data_2_out <= '0;
      wb_busy_out      <= 1'b0;
      wb_done_out      <= 1'b0;
      wb_err_out       <= 1'b0;
    end else begin
      ub_wr_en_1_out <= 1'b0;
      ub_wr_en_2_out <= 1'b0;
      issue_reg      <= 1'b0;
      wb_done_out    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (wb_start_in) begin
            base_reg      <= wb_base_addr_in;
            rows_reg      <= wb_row_count_in;
            transpose_reg <= wb_transpose_in;
            row_cnt_reg   <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            wb_err_out    <= 1'b0;
            if (wb_row_count_in == '0) begin
              // Empty job: complete immediately
              state_reg   <= DONE;
              wb_done_out <= 1'b1;
              wb_busy_out <= 1'b0;
            end else begin
              state_reg   <= ACTIVE;
              wb_busy_out <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          count_reg <= count_next;
          if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          if (underflow || overflow) wb_err_out <= 1'b1;
          if (pair_ok) begin
            issue_reg        <= 1'b1;
            ub_wr_en_1_out   <= !oob_1;
            ub_wr_en_2_out   <= !oob_2;
            ub_wr_addr_1_out <= addr_1_next;
            ub_wr_addr_2_out <= addr_2_next;
            ub_wr_data_1_out <= pair_data_1;
            ub_wr_data_2_out <= wb_data_in_2;
            row_cnt_reg      <= row_cnt_reg + ADDR_W'(1);
            if (oob_1 || oob_2) wb_err_out <= 1'b1;
          end
          if (last_issue) begin
            // Leftover lane-1 data is discarded and reported
            state_reg   <= DONE;
            wb_done_out <= 1'b1;
            wb_busy_out <= 1'b0;
            count_reg   <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            if (count_next != '0) wb_err_out <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
